// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Pipeline hazard controller for a five-stage core whose conditional branches
// (CBZ, B.LT) resolve in ID. It decides, every cycle, whether the pipeline
// runs normally, stalls the front end (load-use or flag hazard), flushes
// IF/ID (taken branch), or freezes entirely (data memory busy).
//
// Optional feature: define HAZARD_PERF_CNT_EN to build the stall/flush
// performance counters. Without it the counter outputs are constant zero and
// no counter flops exist.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   id_rn, id_rm        source registers of the ID instruction
//   id_uses_rn/rm       ID instruction really reads that source
//   id_is_cbz/blt       ID instruction is CBZ / B.LT
//   id_branch_taken     branch-select from the ID branch logic
//   idex_memread        ID/EX holds a load
//   idex_flagen         ID/EX holds a flag-setting op
//   idex_rd             destination register of the ID/EX instruction
//   dmem_busy           data memory not ready this cycle
//   pc_en .. memwb_en   pipeline register write enables
//   ifid_flush          load a NOP into IF/ID on the next edge
//   idex_bubble         zero ID/EX control fields on the next edge
//   stall_cnt           number of stall cycles seen
//   flush_cnt           number of IF/ID flush cycles seen
//
// Handshake: none; every output is a per-cycle command that takes effect on
// the next rising edge of clk.
// ---------------------------------------------------------------------------
module hazard_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rn,
    input  logic [4:0]  id_rm,
    input  logic        id_uses_rn,
    input  logic        id_uses_rm,
    input  logic        id_is_cbz,
    input  logic        id_is_blt,
    input  logic        id_branch_taken,
    input  logic        idex_memread,
    input  logic        idex_flagen,
    input  logic [4:0]  idex_rd,
    input  logic        dmem_busy,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    // LU_HOLD is the second stall cycle a CBZ needs after a load: the loaded
    // value only becomes forwardable into ID once the load reaches WB.
    typedef enum logic {
        RUN     = 1'b0,
        LU_HOLD = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic lu_hit;
    logic fl_hit;
    logic stall_cond;

    // X31 is the zero register, so a load targeting it never creates a hazard.
    assign lu_hit = idex_memread && (idex_rd != 5'd31) &&
                    ((id_uses_rn && (id_rn == idex_rd)) ||
                     (id_uses_rm && (id_rm == idex_rd)));

    // B.LT reads flags that the instruction in EX is still producing.
    assign fl_hit = id_is_blt && idex_flagen;

    assign stall_cond = (state == LU_HOLD) || lu_hit || fl_hit;

    // Output decode in priority order: reset, memory busy, stall, flush.
    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        next_state  = RUN;

        if (rst) begin
            next_state = RUN;
        end else if (dmem_busy) begin
            // Whole pipeline frozen; state (LU_HOLD included) is held.
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            memwb_en   = 1'b0;
            next_state = state;
        end else if (stall_cond) begin
            // Front end holds, a bubble enters EX; branch decision ignored
            // and re-evaluated once the stall clears.
            pc_en       = 1'b0;
            ifid_en     = 1'b0;
            idex_bubble = 1'b1;
            if ((state == RUN) && lu_hit && id_is_cbz) begin
                next_state = LU_HOLD;
            end else begin
                next_state = RUN;
            end
        end else if (id_branch_taken) begin
            ifid_flush = 1'b1;
            next_state = RUN;
        end else begin
            next_state = RUN;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic is_stall;
    logic is_flush;

    assign is_stall = !rst && !dmem_busy && stall_cond;
    assign is_flush = !rst && !dmem_busy && !stall_cond && id_branch_taken;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            state <= next_state;
            // Counters wrap naturally at 2^32.
            if (is_stall) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
            if (is_flush) begin
                flush_cnt <= flush_cnt + 32'd1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed scenarios followed by randomized traffic for hazard_ctrl. The
// reference model classifies every cycle as NORMAL / BUSY / STALL / FLUSH
// from the rules (hazard equations, a count of owed CBZ stall cycles,
// priority order) and maps the class to the expected output vector.
// Inputs change just after the falling edge; combinational outputs are
// checked #1 later, counters #1 after the rising edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    // ------------------------------------------------------------- clock/reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [4:0]  id_rn, id_rm, idex_rd;
    logic        id_uses_rn, id_uses_rm, id_is_cbz, id_is_blt, id_branch_taken;
    logic        idex_memread, idex_flagen, dmem_busy;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_bubble;
    logic [31:0] stall_cnt, flush_cnt;

    hazard_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .id_rn           (id_rn),
        .id_rm           (id_rm),
        .id_uses_rn      (id_uses_rn),
        .id_uses_rm      (id_uses_rm),
        .id_is_cbz       (id_is_cbz),
        .id_is_blt       (id_is_blt),
        .id_branch_taken (id_branch_taken),
        .idex_memread    (idex_memread),
        .idex_flagen     (idex_flagen),
        .idex_rd         (idex_rd),
        .dmem_busy       (dmem_busy),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt)
    );

    // ------------------------------------------------------------- scoreboard
    int total = 0;
    int bad   = 0;

    // Expected output vector: {pc, ifid, idex, exmem, memwb, flush, bubble}
    localparam logic [6:0] V_NORMAL = 7'b11111_0_0;
    localparam logic [6:0] V_BUSY   = 7'b00000_0_0;
    localparam logic [6:0] V_STALL  = 7'b00111_0_1;
    localparam logic [6:0] V_FLUSH  = 7'b11111_1_0;

    logic [6:0] exp_q[$];

    // Model state: stall cycles still owed to a CBZ after a load, and counts.
    int          owed_stalls = 0;
    int unsigned m_stalls    = 0;
    int unsigned m_flushes   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------- driver
    task automatic idle_inputs();
        rst = 1'b0; id_rn = 5'd0; id_rm = 5'd0; idex_rd = 5'd0;
        id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_is_cbz = 1'b0; id_is_blt = 1'b0;
        id_branch_taken = 1'b0; idex_memread = 1'b0; idex_flagen = 1'b0;
        dmem_busy = 1'b0;
    endtask

    task automatic load_to(input logic [4:0] rd);
        idex_memread = 1'b1; idex_rd = rd;
    endtask

    // One clock cycle: predict, check outputs, clock, check counters.
    task automatic step(input string tag);
        logic [6:0]  exp_v;
        logic [6:0]  obs_v;
        logic [31:0] exp_sc;
        logic [31:0] exp_fc;
        bit lu, fl;
        lu = idex_memread && (idex_rd != 5'd31) &&
             ((id_uses_rn && id_rn == idex_rd) || (id_uses_rm && id_rm == idex_rd));
        fl = id_is_blt && idex_flagen;

        if (rst) begin
            exp_v = V_NORMAL;
            owed_stalls = 0; m_stalls = 0; m_flushes = 0;
        end else if (dmem_busy) begin
            exp_v = V_BUSY;
        end else if (owed_stalls > 0 || lu || fl) begin
            exp_v = V_STALL;
            m_stalls = m_stalls + 1;
            if (owed_stalls > 0) owed_stalls = owed_stalls - 1;
            else if (lu && id_is_cbz) owed_stalls = 1;
        end else if (id_branch_taken) begin
            exp_v = V_FLUSH;
            m_flushes = m_flushes + 1;
        end else begin
            exp_v = V_NORMAL;
        end
        exp_q.push_back(exp_v);

        #1;
        obs_v = {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_bubble};
        check({tag, ".ctl"}, {25'd0, obs_v}, {25'd0, exp_q.pop_front()});

        @(posedge clk);
        #1;
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = m_stalls;
        exp_fc = m_flushes;
`else
        exp_sc = 32'd0;
        exp_fc = 32'd0;
`endif
        check({tag, ".stall_cnt"}, stall_cnt, exp_sc);
        check({tag, ".flush_cnt"}, flush_cnt, exp_fc);
        @(negedge clk);
    endtask

    function automatic logic [4:0] pick_reg();
        int r;
        r = $urandom_range(0, 9);
        if (r == 9) return 5'd31;
        return 5'(r % 4);
    endfunction

    // ------------------------------------------------------------- sequence
    initial begin
        idle_inputs();
        @(negedge clk);

        // Reset forces normal outputs even with a hazard on the inputs.
        rst = 1'b1; load_to(5'd3); id_uses_rn = 1'b1; id_rn = 5'd3; dmem_busy = 1'b1;
        step("reset_hazard");
        idle_inputs(); rst = 1'b1;
        step("reset_idle");
        idle_inputs();
        step("after_reset");

        // Load-use on Rn: one stall, then normal.
        load_to(5'd3); id_uses_rn = 1'b1; id_rn = 5'd3;
        step("lu_add_stall");
        idle_inputs(); id_uses_rn = 1'b1; id_rn = 5'd3;
        step("lu_add_resume");

        // Load-use into CBZ: two stalls, second comes from the held state.
        load_to(5'd3); id_uses_rm = 1'b1; id_rm = 5'd3; id_is_cbz = 1'b1;
        step("lu_cbz_1");
        idex_memread = 1'b0;
        step("lu_cbz_2");
        step("lu_cbz_done");

        // B.LT behind a flag setter: stall suppresses flush, then flush.
        idle_inputs(); id_is_blt = 1'b1; idex_flagen = 1'b1; id_branch_taken = 1'b1;
        step("blt_stall");
        idex_flagen = 1'b0;
        step("blt_flush");

        // Memory busy arriving in the held CBZ state.
        idle_inputs(); load_to(5'd7); id_uses_rn = 1'b1; id_rn = 5'd7; id_is_cbz = 1'b1;
        step("busy_enter");
        idex_memread = 1'b0; dmem_busy = 1'b1;
        step("busy_1");
        step("busy_2");
        step("busy_3");
        dmem_busy = 1'b0;
        step("busy_held_stall");
        step("busy_run");

        // Reset in the held state, then X31 load is harmless.
        idle_inputs(); load_to(5'd2); id_uses_rm = 1'b1; id_rm = 5'd2; id_is_cbz = 1'b1;
        step("rst_enter");
        idex_memread = 1'b0; rst = 1'b1;
        step("rst_in_hold");
        idle_inputs();
        step("rst_released");
        load_to(5'd31); id_uses_rn = 1'b1; id_rn = 5'd31; id_uses_rm = 1'b1; id_rm = 5'd31;
        step("x31_no_stall");

        // Randomized traffic from a small register pool to provoke hits.
        for (int i = 0; i < 400; i++) begin
            rst             = ($urandom_range(0, 49) == 0);
            dmem_busy       = ($urandom_range(0, 7) == 0);
            idex_memread    = ($urandom_range(0, 1) == 0);
            idex_flagen     = ($urandom_range(0, 2) == 0);
            idex_rd         = pick_reg();
            id_rn           = pick_reg();
            id_rm           = pick_reg();
            id_uses_rn      = 1'($urandom_range(0, 1));
            id_uses_rm      = 1'($urandom_range(0, 1));
            id_is_cbz       = ($urandom_range(0, 3) == 0);
            id_is_blt       = !id_is_cbz && ($urandom_range(0, 3) == 0);
            id_branch_taken = 1'($urandom_range(0, 1));
            step("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
